// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and execute-side handshake bundle of the decode stage
//
// Purpose: groups the upstream (instruction in) and downstream (decoded bundle out)
//          valid/ready channels of decode_stage.
// Signals:
//   in_valid/in_ready/in_instr/in_pc                   fetch -> decode channel
//   out_valid/out_ready/out_ctrl/out_pc/out_instr/out_illegal   decode -> execute channel
// Modports:
//   slave  - the decode stage itself
//   master - the environment (fetch source and execute sink)
// CTRL_W must equal $bits(decoder_pkg::dec_ctrl_t).

interface decode_stage_if #(
  parameter int CTRL_W = 88
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [31:0]       in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [31:0]       out_pc;
  logic [31:0]       out_instr;
  logic              out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_ctrl, out_pc, out_instr, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_ctrl, out_pc, out_instr, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I(+M,+Zicsr) decode stage with skid buffer
//
// Purpose: decodes raw instruction words into a dec_ctrl_t bundle, flags illegal
//          encodings, suppresses x0 writes and counts legal instructions handed on.
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   flush      synchronous drop of every held instruction
//   bus        decode_stage_if.slave: in_* from fetch, out_* to execute
//   dec_count  number of legal instructions transferred to execute (wraps)

package decoder_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ALUI   = 7'b0010011;
  localparam logic [6:0] OPC_ALU    = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Encoded as funct3 so the ALU op is a straight copy; SUB/SRA use sub_arith.
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SRL  = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2} alu_a_sel_t;
  typedef enum logic       {B_RS2 = 1'b0, B_IMM = 1'b1} alu_b_sel_t;
  typedef enum logic [2:0] {WB_ALU = 3'd0, WB_MEM = 3'd1, WB_PC4 = 3'd2,
                            WB_CSR = 3'd3, WB_MUL = 3'd4} wb_sel_t;

  typedef struct packed {
    logic [31:0] imm;
    logic [11:0] csr_addr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        branch_instr;
    logic        branch_always;
    logic [2:0]  branch_cond;
    alu_op_t     alu_op;
    alu_a_sel_t  alu_a_sel;
    alu_b_sel_t  alu_b_sel;
    logic        sub_arith;
    logic [3:0]  mul_op;          // [3]=M-group op, [2:0]=funct3
    logic        dmem_read_enable;
    logic        dmem_write_enable;
    logic [1:0]  dmem_size;
    logic        dmem_unsigned;
    logic        csr_enable;
    logic [1:0]  csr_op;
    logic        csr_imm;
    logic        wb_write_enable;
    wb_sel_t     wb_mux_sel;
  } dec_ctrl_t;

endpackage

module decode_stage
  import decoder_pkg::*;
#(
  parameter int M_EXT = 1,
  parameter int ZICSR = 1,
  parameter int SKID  = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  decode_stage_if.slave    bus,
  output logic [CNT_W-1:0] dec_count
);

  typedef struct packed {
    dec_ctrl_t   ctrl;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        illegal;
  } slot_t;

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;

  state_t           state_q;
  logic             in_ready_q;
  slot_t            out_q;
  slot_t            skid_q;
  logic [CNT_W-1:0] count_q;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  dec_ctrl_t   ctrl;
  logic        illegal;
  slot_t       slot_d;
  logic        out_valid;
  logic        in_ready;
  logic        accept;
  logic        drain;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Every recognised opcode ends in 2'b11, so a full 7-bit opcode match also
  // rejects compressed/short encodings through the default arm.
  always_comb begin
    ctrl          = '0;
    illegal       = 1'b0;
    ctrl.rs1      = instr[19:15];
    ctrl.rs2      = instr[24:20];
    ctrl.rd       = instr[11:7];
    ctrl.csr_addr = instr[31:20];
    case (opcode)
      OPC_LUI: begin
        ctrl.imm             = imm_u;
        ctrl.alu_a_sel       = A_ZERO;
        ctrl.alu_b_sel       = B_IMM;
        ctrl.wb_write_enable = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.imm             = imm_u;
        ctrl.alu_a_sel       = A_PC;
        ctrl.alu_b_sel       = B_IMM;
        ctrl.wb_write_enable = 1'b1;
      end
      OPC_JAL: begin
        ctrl.imm             = imm_j;
        ctrl.branch_instr    = 1'b1;
        ctrl.branch_always   = 1'b1;
        ctrl.alu_a_sel       = A_PC;
        ctrl.alu_b_sel       = B_IMM;
        ctrl.wb_write_enable = 1'b1;
        ctrl.wb_mux_sel      = WB_PC4;
      end
      OPC_JALR: begin
        if (funct3 != 3'b000) illegal = 1'b1;
        ctrl.imm             = imm_i;
        ctrl.branch_instr    = 1'b1;
        ctrl.branch_always   = 1'b1;
        ctrl.alu_b_sel       = B_IMM;
        ctrl.wb_write_enable = 1'b1;
        ctrl.wb_mux_sel      = WB_PC4;
      end
      OPC_BRANCH: begin
        if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
        ctrl.imm          = imm_b;
        ctrl.branch_instr = 1'b1;
        ctrl.branch_cond  = funct3;
      end
      OPC_LOAD: begin
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal = 1'b1;
        ctrl.imm              = imm_i;
        ctrl.alu_b_sel        = B_IMM;
        ctrl.dmem_read_enable = 1'b1;
        ctrl.dmem_size        = funct3[1:0];
        ctrl.dmem_unsigned    = funct3[2];
        ctrl.wb_write_enable  = 1'b1;
        ctrl.wb_mux_sel       = WB_MEM;
      end
      OPC_STORE: begin
        if (funct3 >= 3'b011) illegal = 1'b1;
        ctrl.imm               = imm_s;
        ctrl.alu_b_sel         = B_IMM;
        ctrl.dmem_write_enable = 1'b1;
        ctrl.dmem_size         = funct3[1:0];
      end
      OPC_ALUI: begin
        ctrl.imm             = imm_i;
        ctrl.alu_op          = alu_op_t'(funct3);
        ctrl.alu_b_sel       = B_IMM;
        ctrl.wb_write_enable = 1'b1;
        // Shift-immediates reuse imm[11:5] as a funct7 qualifier.
        if (funct3 == 3'b001) begin
          if (funct7 != 7'b0000000) illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0100000) ctrl.sub_arith = 1'b1;
          else if (funct7 != 7'b0000000) illegal = 1'b1;
        end
      end
      OPC_ALU: begin
        ctrl.alu_op          = alu_op_t'(funct3);
        ctrl.wb_write_enable = 1'b1;
        case (funct7)
          7'b0000000: ;
          7'b0100000: begin
            if (funct3 != 3'b000 && funct3 != 3'b101) illegal = 1'b1;
            ctrl.sub_arith = 1'b1;
          end
          7'b0000001: begin
            if (M_EXT != 0) begin
              ctrl.mul_op     = {1'b1, funct3};
              ctrl.wb_mux_sel = WB_MUL;
            end else begin
              illegal = 1'b1;
            end
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_FENCE: ;
      OPC_SYSTEM: begin
        // funct3=000 (ECALL/EBREAK/xRET) carries no side effects here; execute
        // inspects out_instr for those.
        if (funct3 == 3'b100) begin
          illegal = 1'b1;
        end else if (funct3 != 3'b000) begin
          if (ZICSR == 0) illegal = 1'b1;
          ctrl.csr_enable      = 1'b1;
          ctrl.csr_op          = funct3[1:0];
          ctrl.csr_imm         = funct3[2];
          ctrl.imm             = {27'b0, instr[19:15]};
          ctrl.wb_write_enable = 1'b1;
          ctrl.wb_mux_sel      = WB_CSR;
        end
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctrl.wb_write_enable   = 1'b0;
      ctrl.dmem_write_enable = 1'b0;
      ctrl.csr_enable        = 1'b0;
      ctrl.branch_instr      = 1'b0;
      ctrl.branch_always     = 1'b0;
    end
    if (ctrl.rd == 5'd0) ctrl.wb_write_enable = 1'b0;
  end

  assign slot_d = '{ctrl: ctrl, pc: bus.in_pc, instr: instr, illegal: illegal};

  assign out_valid = (state_q != S_EMPTY);
  // With the skid buffer in_ready is a register so it never sees out_ready;
  // without it the stage only passes through when its output moves.
  assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign drain     = out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
      count_q    <= '0;
    end else if (flush) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      if (drain && !out_q.illegal) count_q <= count_q + CNT_W'(1);
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            out_q   <= slot_d;
            state_q <= S_ONE;
          end
        end
        S_ONE: begin
          if (accept && drain) begin
            out_q <= slot_d;
          end else if (accept) begin
            // Output stalled: park the new word so out_* stays stable.
            skid_q     <= slot_d;
            state_q    <= S_TWO;
            in_ready_q <= 1'b0;
          end else if (drain) begin
            state_q <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (drain) begin
            out_q      <= skid_q;
            state_q    <= S_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_ctrl    = out_q.ctrl;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_instr   = out_q.instr;
  assign bus.out_illegal = out_q.illegal;
  assign dec_count       = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage

module tb_decode_stage;
  import decoder_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;
  int          n_checks;
  int          n_fail;

  decode_stage_if #(.CTRL_W($bits(dec_ctrl_t))) ifa ();
  decode_stage_if #(.CTRL_W($bits(dec_ctrl_t))) ifb ();

  decode_stage #(.M_EXT(1), .ZICSR(1), .SKID(1), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(ifa.slave), .dec_count(cnt_a)
  );

  decode_stage #(.M_EXT(0), .ZICSR(1), .SKID(1), .CNT_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(ifb.slave), .dec_count(cnt_b)
  );

  dec_ctrl_t ca, cb;
  assign ca = ifa.out_ctrl;
  assign cb = ifb.out_ctrl;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_instr = '0; ifa.in_pc = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_instr = '0; ifb.in_pc = '0; ifb.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", ifa.out_valid); end
    n_checks++; if (cnt_a !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cnt_a); end
    n_checks++; if (ifa.out_ctrl !== '0 || ifa.out_pc !== 32'd0 || ifa.out_instr !== 32'd0 || ifa.out_illegal !== 1'b0) begin
      n_fail++; $display("FAIL reset_payload: got ctrl=%h pc=%h instr=%h ill=%b want all 0", ifa.out_ctrl, ifa.out_pc, ifa.out_instr, ifa.out_illegal);
    end
    @(negedge clk); reset_n = 1'b1;
    cyc();
    n_checks++; if (ifa.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", ifa.in_ready); end
  endtask

  task automatic test_addi();
    ifa.in_valid = 1'b1; ifa.in_instr = 32'h00500093; ifa.in_pc = 32'h100;
    cyc();
    ifa.in_valid = 1'b0;
    n_checks++; if (ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b want 1", ifa.out_valid); end
    n_checks++; if (ca.imm !== 32'd5) begin n_fail++; $display("FAIL addi_imm: got %h want 5", ca.imm); end
    n_checks++; if (ca.rd !== 5'd1 || ca.wb_write_enable !== 1'b1) begin n_fail++; $display("FAIL addi_rd_we: got rd=%0d we=%b want rd=1 we=1", ca.rd, ca.wb_write_enable); end
    n_checks++; if (ca.alu_op !== ALU_ADD || ca.alu_b_sel !== B_IMM) begin n_fail++; $display("FAIL addi_alu: got op=%0d bsel=%0d want 0/1", ca.alu_op, ca.alu_b_sel); end
    n_checks++; if (ifa.out_pc !== 32'h100 || ifa.out_illegal !== 1'b0) begin n_fail++; $display("FAIL addi_pc: got pc=%h ill=%b want 100/0", ifa.out_pc, ifa.out_illegal); end
    cyc();
    n_checks++; if (cnt_a !== 32'd1 || ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_count: got cnt=%0d valid=%b want 1/0", cnt_a, ifa.out_valid); end
  endtask

  task automatic test_mul();
    ifa.in_valid = 1'b1; ifa.in_instr = 32'h022081B3; ifa.in_pc = 32'h104;
    ifb.in_valid = 1'b1; ifb.in_instr = 32'h022081B3; ifb.in_pc = 32'h104;
    cyc();
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    n_checks++; if (ca.wb_mux_sel !== WB_MUL || ifa.out_illegal !== 1'b0 || ca.wb_write_enable !== 1'b1) begin
      n_fail++; $display("FAIL mul_mext1: got sel=%0d ill=%b we=%b want 4/0/1", ca.wb_mux_sel, ifa.out_illegal, ca.wb_write_enable);
    end
    n_checks++; if (ca.mul_op !== 4'b1000) begin n_fail++; $display("FAIL mul_op: got %b want 1000", ca.mul_op); end
    n_checks++; if (ifb.out_illegal !== 1'b1 || cb.wb_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL mul_mext0: got ill=%b we=%b want 1/0", ifb.out_illegal, cb.wb_write_enable);
    end
    cyc();
    n_checks++; if (cnt_a !== 32'd2 || cnt_b !== 4'd0) begin n_fail++; $display("FAIL mul_count: got a=%0d b=%0d want 2/0", cnt_a, cnt_b); end
  endtask

  task automatic test_x0_and_illegal_words();
    logic [31:0] w [3] = '{32'h00208033, 32'h00000000, 32'hFFFFFFFF};
    logic        ill [3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      ifa.in_valid = 1'b1; ifa.in_instr = w[i]; ifa.in_pc = 32'h200 + i * 4;
      cyc();
      n_checks++; if (ifa.out_valid !== 1'b1 || ifa.out_instr !== w[i] || ifa.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_flow[%0d]: got v=%b instr=%h rdy=%b want 1/%h/1", i, ifa.out_valid, ifa.out_instr, ifa.in_ready, w[i]);
      end
      n_checks++; if (ifa.out_illegal !== ill[i] || ca.wb_write_enable !== 1'b0) begin
        n_fail++; $display("FAIL x0_illegal[%0d]: got ill=%b we=%b want %b/0", i, ifa.out_illegal, ca.wb_write_enable, ill[i]);
      end
    end
    ifa.in_valid = 1'b0;
    cyc();
    n_checks++; if (cnt_a !== 32'd3) begin n_fail++; $display("FAIL x0_count: got %0d want 3", cnt_a); end
  endtask

  task automatic test_imm();
    logic [31:0] w [5]   = '{32'hFE20AE23, 32'hFE000CE3, 32'h001000EF, 32'h123452B7, 32'hFFF00093};
    logic [31:0] imm [5] = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000800, 32'h12345000, 32'hFFFFFFFF};
    for (int i = 0; i < 5; i++) begin
      ifa.in_valid = 1'b1; ifa.in_instr = w[i]; ifa.in_pc = 32'h300 + i * 4;
      cyc();
      n_checks++; if (ca.imm !== imm[i] || ifa.out_illegal !== 1'b0) begin
        n_fail++; $display("FAIL imm[%0d]: got imm=%h ill=%b want %h/0", i, ca.imm, ifa.out_illegal, imm[i]);
      end
    end
    ifa.in_valid = 1'b0;
    cyc();
    n_checks++; if (cnt_a !== 32'd8) begin n_fail++; $display("FAIL imm_count: got %0d want 8", cnt_a); end
  endtask

  task automatic test_illegal_rules();
    logic [31:0] w [19] = '{32'h40000033, 32'h40001033, 32'h40005013, 32'h40001013, 32'h02001013,
                            32'h00002003, 32'h00003003, 32'h00006003, 32'h00003023, 32'h00002023,
                            32'h00002063, 32'h00001067, 32'h00004073, 32'h00001073, 32'h00500091,
                            32'h00000073, 32'h0000000F, 32'h02006033, 32'h40002033};
    logic ill [19] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                       1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                       1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                       1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 19; i++) begin
      ifa.in_valid = 1'b1; ifa.in_instr = w[i]; ifa.in_pc = 32'h400 + i * 4;
      cyc();
      n_checks++; if (ifa.out_illegal !== ill[i]) begin
        n_fail++; $display("FAIL illegal_rule[%0d] %h: got %b want %b", i, w[i], ifa.out_illegal, ill[i]);
      end
      if (ill[i]) begin
        n_checks++;
        if ({ca.wb_write_enable, ca.dmem_write_enable, ca.csr_enable, ca.branch_instr, ca.branch_always} !== 5'b0) begin
          n_fail++; $display("FAIL illegal_side_effects[%0d]: got we/dwe/csr/br/bra=%b%b%b%b%b want 00000", i,
                             ca.wb_write_enable, ca.dmem_write_enable, ca.csr_enable, ca.branch_instr, ca.branch_always);
        end
      end
    end
    ifa.in_valid = 1'b0;
    cyc();
    n_checks++; if (cnt_a !== 32'd16) begin n_fail++; $display("FAIL illegal_count: got %0d want 16", cnt_a); end
  endtask

  task automatic test_back_to_back_stall();
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_instr = 32'h00100093; ifa.in_pc = 32'h500;
    cyc();
    n_checks++; if (ifa.in_ready !== 1'b1 || ifa.out_instr !== 32'h00100093) begin
      n_fail++; $display("FAIL stall_one: got rdy=%b instr=%h want 1/00100093", ifa.in_ready, ifa.out_instr);
    end
    ifa.in_instr = 32'h00200113; ifa.in_pc = 32'h504;
    cyc();
    n_checks++; if (ifa.in_ready !== 1'b0 || ifa.out_instr !== 32'h00100093) begin
      n_fail++; $display("FAIL stall_two: got rdy=%b instr=%h want 0/00100093", ifa.in_ready, ifa.out_instr);
    end
    ifa.in_instr = 32'h00300193; ifa.in_pc = 32'h508;
    cyc();
    n_checks++; if (ifa.in_ready !== 1'b0 || ifa.out_instr !== 32'h00100093 || ifa.out_pc !== 32'h500 || ca.imm !== 32'd1) begin
      n_fail++; $display("FAIL stall_stable: got rdy=%b instr=%h pc=%h imm=%h want 0/00100093/500/1", ifa.in_ready, ifa.out_instr, ifa.out_pc, ca.imm);
    end
    ifa.out_ready = 1'b1;
    cyc();
    n_checks++; if (ifa.out_instr !== 32'h00200113 || ca.imm !== 32'd2 || ifa.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_drain1: got instr=%h imm=%h rdy=%b want 00200113/2/1", ifa.out_instr, ca.imm, ifa.in_ready);
    end
    cyc();
    n_checks++; if (ifa.out_instr !== 32'h00300193 || ifa.out_pc !== 32'h508 || ca.rd !== 5'd3) begin
      n_fail++; $display("FAIL stall_drain2: got instr=%h pc=%h rd=%0d want 00300193/508/3", ifa.out_instr, ifa.out_pc, ca.rd);
    end
    ifa.in_valid = 1'b0;
    cyc();
    n_checks++; if (ifa.out_valid !== 1'b0 || cnt_a !== 32'd19) begin
      n_fail++; $display("FAIL stall_count: got v=%b cnt=%0d want 0/19", ifa.out_valid, cnt_a);
    end
  endtask

  task automatic test_flush();
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_instr = 32'h00400093; ifa.in_pc = 32'h600;
    cyc();
    ifa.in_instr = 32'h00500093; ifa.in_pc = 32'h604;
    cyc();
    n_checks++; if (ifa.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pre_two: got rdy=%b want 0", ifa.in_ready); end
    flush = 1'b1; ifa.in_instr = 32'h00600093; ifa.in_pc = 32'h608;
    cyc();
    n_checks++; if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_state: got v=%b rdy=%b want 0/1", ifa.out_valid, ifa.in_ready);
    end
    flush = 1'b0; ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
    cyc();
    n_checks++; if (ifa.out_valid !== 1'b0 || cnt_a !== 32'd19) begin
      n_fail++; $display("FAIL flush_drop: got v=%b cnt=%0d want 0/19", ifa.out_valid, cnt_a);
    end
  endtask

  task automatic test_count_wrap();
    for (int i = 0; i < 17; i++) begin
      ifb.in_valid = 1'b1; ifb.in_instr = 32'h00100093; ifb.in_pc = i * 4;
      cyc();
      if (i == 15) begin
        n_checks++; if (cnt_b !== 4'hF) begin n_fail++; $display("FAIL wrap_15: got %0d want 15", cnt_b); end
      end
      if (i == 16) begin
        n_checks++; if (cnt_b !== 4'h0) begin n_fail++; $display("FAIL wrap_16: got %0d want 0", cnt_b); end
      end
    end
    ifb.in_valid = 1'b0;
    cyc();
    n_checks++; if (cnt_b !== 4'd1 || ifb.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL wrap_17: got cnt=%0d v=%b want 1/0", cnt_b, ifb.out_valid);
    end
  endtask

  task automatic test_async_reset();
    ifa.out_ready = 1'b0; ifb.out_ready = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_instr = 32'h00700093; ifa.in_pc = 32'h700;
    ifb.in_valid = 1'b1; ifb.in_instr = 32'h00700093; ifb.in_pc = 32'h700;
    cyc();
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    n_checks++; if (ifa.out_valid !== 1'b1 || ifb.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre: got va=%b vb=%b want 1/1", ifa.out_valid, ifb.out_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (ifa.out_valid !== 1'b0 || ifb.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL areset_valid: got va=%b vb=%b want 0/0", ifa.out_valid, ifb.out_valid);
    end
    n_checks++; if (cnt_a !== 32'd0 || cnt_b !== 4'd0) begin
      n_fail++; $display("FAIL areset_count: got a=%0d b=%0d want 0/0", cnt_a, cnt_b);
    end
    @(negedge clk); reset_n = 1'b1;
    ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
    cyc();
    n_checks++; if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL areset_release: got rdy=%b v=%b want 1/0", ifa.in_ready, ifa.out_valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_addi();
    test_mul();
    test_x0_and_illegal_words();
    test_imm();
    test_illegal_rules();
    test_back_to_back_stall();
    test_flush();
    test_count_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
